// File: rtl/seg_pattern_decoder_if.sv
// Bus between a 7-segment pattern source and seg_pattern_decoder.
// The source drives sample_en/seg_in. The decoder drives the decoded
// result, the status flags and the debug state.
// Handshake: there is no back-pressure. seg_in is taken only on cycles where
// sample_en is 1. Every result is a registered level or a single-cycle pulse,
// and it is valid the cycle after the sample that caused it.
interface seg_pattern_decoder_if #(
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [6:0]       seg_in;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             new_digit;
    logic             blank;
    logic             seg_err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    // Pattern source side.
    modport master (
        output sample_en,
        output seg_in,
        input  digit,
        input  digit_valid,
        input  new_digit,
        input  blank,
        input  seg_err,
        input  err_count,
        input  state
    );

    // Decoder side.
    modport slave (
        input  sample_en,
        input  seg_in,
        output digit,
        output digit_valid,
        output new_digit,
        output blank,
        output seg_err,
        output err_count,
        output state
    );
endinterface

// File: rtl/seg_pattern_decoder.sv
// Reads back an active-low 7-segment bus (bit0=a .. bit6=g).
// A pattern must be seen on STABLE_CYCLES consecutive enabled samples before
// it is committed. The committed pattern is then classified:
//   - a legal hex glyph sets digit and digit_valid, and pulses new_digit;
//   - all segments off (7'h7F) sets the blank flag;
//   - any other pattern pulses seg_err and bumps a saturating counter.
// A stable pattern commits once. It commits again only after a different
// pattern has been seen in between.
module seg_pattern_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_pattern_decoder_if.slave bus
);

    localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [6:0]       held_q, held_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             blank_q, blank_d;
    logic             new_digit_q, new_digit_d;
    logic             seg_err_q, seg_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             dec_legal;
    logic             dec_blank;
    logic [3:0]       dec_value;
    logic             do_commit;
    logic             new_pattern;

    // Classify the incoming bus pattern. A commit only ever happens when
    // seg_in equals the held pattern, so decoding seg_in is enough.
    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_value = 4'h0;
        case (bus.seg_in)
            7'h40:   dec_value = 4'h0;
            7'h79:   dec_value = 4'h1;
            7'h24:   dec_value = 4'h2;
            7'h30:   dec_value = 4'h3;
            7'h19:   dec_value = 4'h4;
            7'h12:   dec_value = 4'h5;
            7'h02:   dec_value = 4'h6;
            7'h78:   dec_value = 4'h7;
            7'h00:   dec_value = 4'h8;
            7'h10:   dec_value = 4'h9;
            7'h08:   dec_value = 4'hA;
            7'h03:   dec_value = 4'hB;
            7'h46:   dec_value = 4'hC;
            7'h21:   dec_value = 4'hD;
            7'h06:   dec_value = 4'hE;
            7'h0E:   dec_value = 4'hF;
            SEG_BLANK: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next state: restart the run on a new pattern, count matching samples
    // while qualifying, and apply the commit effects on the qualifying sample.
    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        held_d        = held_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        blank_d       = blank_q;
        new_digit_d   = 1'b0;
        seg_err_d     = 1'b0;
        err_count_d   = err_count_q;
        do_commit     = 1'b0;
        new_pattern   = (state_q != ST_QUALIFY && state_q != ST_LOCKED) ||
                        (bus.seg_in != held_q);

        if (bus.sample_en) begin
            if (new_pattern) begin
                held_d        = bus.seg_in;
                run_d         = RUN_ONE;
                digit_valid_d = 1'b0;
                blank_d       = 1'b0;
                if (STABLE_CYCLES == 1) begin
                    do_commit = 1'b1;
                    state_d   = ST_LOCKED;
                end else begin
                    state_d   = ST_QUALIFY;
                end
            end else if (state_q == ST_QUALIFY) begin
                // The run length is below RUN_MAX here, so the count stops at
                // RUN_MAX and never wraps.
                run_d = run_q + RUN_ONE;
                if (run_d == RUN_MAX) begin
                    do_commit = 1'b1;
                    state_d   = ST_LOCKED;
                end
            end
            // LOCKED on the same pattern: already committed, nothing to do.
        end

        if (do_commit) begin
            if (dec_legal) begin
                digit_d       = dec_value;
                digit_valid_d = 1'b1;
                new_digit_d   = 1'b1;
            end else if (dec_blank) begin
                blank_d = 1'b1;
            end else begin
                seg_err_d = 1'b1;
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + ERR_ONE;
                end
            end
        end
    end

    // State and output registers. Reset drops any pending pattern and
    // returns the held pattern to all segments off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            run_q         <= '0;
            held_q        <= SEG_BLANK;
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            blank_q       <= 1'b0;
            new_digit_q   <= 1'b0;
            seg_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            held_q        <= held_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            blank_q       <= blank_d;
            new_digit_q   <= new_digit_d;
            seg_err_q     <= seg_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.new_digit   = new_digit_q;
    assign bus.blank       = blank_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.err_count   = err_count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder.
// A behavioural model produces the expected output word for every applied
// cycle. The word goes into a queue, and it is popped and compared once the
// registered outputs settle. Directed checks cover the key scenarios.
module tb_seg_pattern_decoder;

    localparam int STABLE = 3;
    localparam int EW     = 8;
    localparam int XW     = 2 + EW + 1 + 1 + 1 + 1 + 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg_pattern_decoder_if #(.ERR_W(EW)) bus ();

    seg_pattern_decoder #(.STABLE_CYCLES(STABLE), .ERR_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock.
    always #5 clk = ~clk;

    // Scoreboard and counters.
    logic [XW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int nd_seen = 0;
    int se_seen = 0;

    // Reference model state.
    int         m_state;
    int         m_run;
    logic [6:0] m_held;
    logic [3:0] m_digit;
    bit         m_valid;
    bit         m_blank;
    bit         m_nd;
    bit         m_se;
    int         m_err;

    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns 0..15 for a legal glyph, 16 for blank, and -1 for anything else.
    function automatic int classify(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (lut[i] == s) return i;
        end
        if (s == 7'h7F) return 16;
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit en, input logic [6:0] s);
        int c;
        m_nd = 0;
        m_se = 0;
        if (rst) begin
            m_state = 0; m_run = 0; m_held = 7'h7F; m_digit = 0;
            m_valid = 0; m_blank = 0; m_err = 0;
            return;
        end
        if (!en) return;
        if (m_state == 0 || s != m_held) begin
            m_held  = s;
            m_run   = 1;
            m_valid = 0;
            m_blank = 0;
            m_state = 1;
        end else if (m_state == 1) begin
            m_run++;
        end
        if (m_state == 1 && m_run == STABLE) begin
            m_state = 2;
            c = classify(m_held);
            if (c >= 0 && c < 16) begin
                m_digit = c[3:0];
                m_valid = 1;
                m_nd    = 1;
            end else if (c == 16) begin
                m_blank = 1;
            end else begin
                m_se = 1;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    function automatic logic [XW-1:0] model_word();
        logic [1:0]    st;
        logic [EW-1:0] ec;
        st = m_state[1:0];
        ec = m_err[EW-1:0];
        return {st, ec, m_se, m_blank, m_nd, m_valid, m_digit};
    endfunction

    // Drive one cycle, predict it, then compare against the settled outputs.
    task automatic apply(input bit rst, input bit en, input logic [6:0] s);
        logic [XW-1:0] got;
        @(negedge clk);
        reset         = rst;
        bus.sample_en = en;
        bus.seg_in    = s;
        model_step(rst, en, s);
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        got = {bus.state, bus.err_count, bus.seg_err, bus.blank,
               bus.new_digit, bus.digit_valid, bus.digit};
        if (bus.new_digit) nd_seen++;
        if (bus.seg_err) se_seen++;
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("sb", 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic run(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b1, s);
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.seg_in    = 7'h00;

        // 1: reset dominates any input.
        apply(1'b1, 1'b1, 7'h30);
        apply(1'b1, 1'b1, 7'h7E);
        check("rst_digit", 32'(bus.digit), 32'd0);
        check("rst_flags", {bus.digit_valid, bus.new_digit, bus.blank, bus.seg_err}, 32'd0);
        check("rst_errcnt", 32'(bus.err_count), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);

        // 2: three samples of '3' commit, and holding it produces no more pulses.
        nd_seen = 0;
        run(7'h30, 3);
        check("t2_pulse", 32'(nd_seen), 32'd1);
        check("t2_digit", 32'(bus.digit), 32'd3);
        check("t2_valid", 32'(bus.digit_valid), 32'd1);
        run(7'h30, 10);
        check("t2_hold_pulses", 32'(nd_seen), 32'd1);

        // 3: an interrupted run must requalify, and the short '2' never commits.
        nd_seen = 0;
        run(7'h30, 2);
        run(7'h24, 1);
        run(7'h30, 2);
        check("t3_no_early", 32'(nd_seen), 32'd0);
        run(7'h30, 1);
        check("t3_pulse", 32'(nd_seen), 32'd1);
        check("t3_digit", 32'(bus.digit), 32'd3);

        // 4: illegal pattern, then blank.
        se_seen = 0;
        run(7'h7E, 3);
        check("t4_seg_err", 32'(se_seen), 32'd1);
        check("t4_errcnt", 32'(bus.err_count), 32'd1);
        check("t4_digit", 32'(bus.digit), 32'd3);
        check("t4_valid", 32'(bus.digit_valid), 32'd0);
        run(7'h7F, 3);
        check("t4_blank", 32'(bus.blank), 32'd1);

        // 5: the error counter saturates.
        for (int i = 0; i < 300; i++) run((i % 2 == 0) ? 7'h7E : 7'h7D, 3);
        check("t5_sat", 32'(bus.err_count), 32'd255);

        // 6: gated sampling, then a reset in the middle of qualification.
        apply(1'b1, 1'b0, 7'h00);
        nd_seen = 0;
        for (int i = 0; i < 5; i++) apply(1'b0, (i % 2 == 0), 7'h12);
        check("t6_pulse", 32'(nd_seen), 32'd1);
        check("t6_digit", 32'(bus.digit), 32'd5);
        nd_seen = 0;
        run(7'h06, 2);
        apply(1'b1, 1'b1, 7'h06);
        check("t6_no_pulse", 32'(nd_seen), 32'd0);
        check("t6_state", 32'(bus.state), 32'd0);

        // Random mix: sticky patterns so runs form, gated sampling, rare reset.
        begin
            logic [6:0] pool [6];
            logic [6:0] cur;
            pool = '{7'h40, 7'h30, 7'h7F, 7'h7E, 7'h12, 7'h0E};
            cur  = pool[0];
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 4) == 0) cur = 7'($urandom_range(0, 127));
                    else cur = pool[$urandom_range(0, 5)];
                end
                apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0), cur);
            end
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
